// File: rtl/k005297_subclk_stopreq_pkg.sv
// Shared types and helpers for the subclock stop-request requester.
package k005297_subclk_stopreq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RUN  = 2'd1,
        ST_RUN       = 2'd2,
        ST_WAIT_STOP = 2'd3
    } state_t;

    localparam int ROT20_SLOTS = 20;

    // The rotator is one-cold: slot k is live when its bit is low.
    function automatic logic rot20_slot_active(input logic [ROT20_SLOTS-1:0] rot20_n,
                                               input logic [4:0]             slot);
        return ~rot20_n[slot];
    endfunction

endpackage

// File: rtl/k005297_ack_timer.sv
// Saturating acknowledge-timeout counter; expiry flags the step that reaches all-ones.
module k005297_ack_timer #(
    parameter int TMO_W = 8
) (
    input  logic i_MCLK,
    input  logic i_MRST_n,
    input  logic clr,
    input  logic en,
    output logic expiry
);

    localparam logic [TMO_W-1:0] ALL_ONES = '1;

    logic [TMO_W-1:0] count;

    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != ALL_ONES)) begin
            count <= count + TMO_W'(1);
        end
    end

    // High one step early so the owner can act on the edge that saturates the count.
    assign expiry = (count >= (ALL_ONES - TMO_W'(1)));

endmodule

// File: rtl/k005297_subclk_stopreq.sv
// Requester side of the 2 MHz subclock start/stop handshake with frame-counted bursts.
//
// state        | meaning
// ST_IDLE      | stop requested, waiting for a start command
// ST_WAIT_RUN  | stop released, waiting for the subclock to report running
// ST_RUN       | subclock running, counting slot-STOP_SLOT frame boundaries
// ST_WAIT_STOP | stop requested, waiting for the subclock to report stopped
module k005297_subclk_stopreq
    import k005297_subclk_stopreq_pkg::*;
#(
    parameter int LEN_W     = 10,
    parameter int TMO_W     = 8,
    parameter int STOP_SLOT = 19
) (
    input  logic                   i_MCLK,
    input  logic                   i_MRST_n,
    input  logic                   i_CLK4M_PCEN_n,
    input  logic                   i_CLK2M_PCEN_n,
    input  logic [ROT20_SLOTS-1:0] i_ROT20_n,
    input  logic                   i_SYS_RUN_FLAG,
    input  logic                   i_CLK2M_STOP_DLYD_n,
    input  logic                   i_START_n,
    input  logic                   i_ABORT_n,
    input  logic [LEN_W-1:0]       i_LEN,
    output logic                   o_CLK2M_STOPRQ_n,
    output logic                   o_BUSY,
    output logic                   o_DONE,
    output logic                   o_ERR,
    output logic [LEN_W-1:0]       o_FRAME_CNT
);

    localparam logic [4:0] STOP_SLOT_IDX = 5'(STOP_SLOT);

    state_t           state, state_nx;
    logic             stoprq_nx, busy_nx, done_nx, err_nx;
    logic [LEN_W-1:0] frame_nx;
    logic             tmr_clr, tmr_inc, tmr_expiry;
    logic             en4, frame_tick, abort_req;
    logic [LEN_W-1:0] len_eff;

    assign en4        = ~i_CLK4M_PCEN_n;
    assign frame_tick = ~i_CLK2M_PCEN_n & rot20_slot_active(i_ROT20_n, STOP_SLOT_IDX);
    assign abort_req  = ~i_ABORT_n | ~i_SYS_RUN_FLAG;
    assign len_eff    = (i_LEN == '0) ? LEN_W'(1) : i_LEN;

    k005297_ack_timer #(.TMO_W(TMO_W)) u_ack_timer (
        .i_MCLK   (i_MCLK),
        .i_MRST_n (i_MRST_n),
        .clr      (tmr_clr & en4),
        .en       (tmr_inc & en4),
        .expiry   (tmr_expiry)
    );

    always_comb begin
        state_nx  = state;
        stoprq_nx = o_CLK2M_STOPRQ_n;
        busy_nx   = o_BUSY;
        done_nx   = 1'b0;
        err_nx    = o_ERR;
        frame_nx  = o_FRAME_CNT;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                stoprq_nx = 1'b0;
                if (!i_START_n && i_SYS_RUN_FLAG) begin
                    frame_nx  = len_eff;
                    err_nx    = 1'b0;
                    busy_nx   = 1'b1;
                    stoprq_nx = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nx  = ST_WAIT_RUN;
                end
            end
            ST_WAIT_RUN: begin
                if (abort_req) begin
                    stoprq_nx = 1'b0;
                    err_nx    = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nx  = ST_WAIT_STOP;
                end else if (i_CLK2M_STOP_DLYD_n) begin
                    tmr_clr  = 1'b1;
                    state_nx = ST_RUN;
                end else if (tmr_expiry) begin
                    stoprq_nx = 1'b0;
                    err_nx    = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nx  = ST_WAIT_STOP;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident final-frame decrement and freezes the count.
                if (abort_req) begin
                    stoprq_nx = 1'b0;
                    err_nx    = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nx  = ST_WAIT_STOP;
                end else if (frame_tick && (o_FRAME_CNT != '0)) begin
                    frame_nx = o_FRAME_CNT - LEN_W'(1);
                    if (o_FRAME_CNT == LEN_W'(1)) begin
                        stoprq_nx = 1'b0;
                        tmr_clr   = 1'b1;
                        state_nx  = ST_WAIT_STOP;
                    end
                end
            end
            ST_WAIT_STOP: begin
                stoprq_nx = 1'b0;
                if (!i_CLK2M_STOP_DLYD_n) begin
                    busy_nx  = 1'b0;
                    done_nx  = ~o_ERR;
                    tmr_clr  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (tmr_expiry) begin
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    tmr_clr  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: begin
                stoprq_nx = 1'b0;
                busy_nx   = 1'b0;
                state_nx  = ST_IDLE;
            end
        endcase
    end

    // Everything advances only on 4 MHz enables, so DONE spans exactly one enable period.
    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state            <= ST_IDLE;
            o_CLK2M_STOPRQ_n <= 1'b0;
            o_BUSY           <= 1'b0;
            o_DONE           <= 1'b0;
            o_ERR            <= 1'b0;
            o_FRAME_CNT      <= '0;
        end else if (en4) begin
            state            <= state_nx;
            o_CLK2M_STOPRQ_n <= stoprq_nx;
            o_BUSY           <= busy_nx;
            o_DONE           <= done_nx;
            o_ERR            <= err_nx;
            o_FRAME_CNT      <= frame_nx;
        end
    end

endmodule
